pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 142 ++++++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter unit: the fetch address register with trap/redirect/pending priority,
// deferral of redirects while the pipeline is held, target alignment and a handshake counter.
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                INST_BYTES   = 4,
  parameter int                CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [WIDTH-1:0]     redirect_target,
  input  logic                 trap_valid,
  input  logic [WIDTH-1:0]     trap_target,
  input  logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [WIDTH-1:0]     fetch_pc,
  output logic                 redirect_pending,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INST_BYTES - 1);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(INST_BYTES);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   fetch_valid_r;
  logic                   fetch_valid_next_s;
  logic [WIDTH-1:0]       fetch_pc_r;
  logic [WIDTH-1:0]       fetch_pc_next_s;
  logic                   pending_r;
  logic                   pending_next_s;
  logic [WIDTH-1:0]       pending_tgt_r;
  logic [WIDTH-1:0]       pending_tgt_next_s;
  logic                   misalign_r;
  logic                   misalign_next_s;
  logic [CNT_WIDTH-1:0]   fetch_count_r;
  logic                   hs_s;
  logic                   can_change_s;

  function automatic logic [WIDTH-1:0] align_f(input logic [WIDTH-1:0] tgt);
    align_f = tgt & ~ALIGN_MASK;
  endfunction

  function automatic logic misaligned_f(input logic [WIDTH-1:0] tgt);
    misaligned_f = |(tgt & ALIGN_MASK);
  endfunction

  assign hs_s         = fetch_valid_r & fetch_ready;
  assign can_change_s = ~stall & (~fetch_valid_r | fetch_ready);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: leave IDLE on the first edge out of reset, then stay in RUN
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = RUN;
      RUN:     state_next_s = RUN;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output: fetch_valid is registered alongside the state it belongs to
  always_comb begin
    fetch_valid_next_s = 1'b0;
    case (state_next_s)
      IDLE:    fetch_valid_next_s = 1'b0;
      RUN:     fetch_valid_next_s = 1'b1;
      default: fetch_valid_next_s = 1'b0;
    endcase
  end

  // PC selection: trap beats everything; redirects apply only when the request may change
  always_comb begin
    fetch_pc_next_s    = fetch_pc_r;
    pending_next_s     = pending_r;
    pending_tgt_next_s = pending_tgt_r;
    misalign_next_s    = 1'b0;
    if (trap_valid) begin
      fetch_pc_next_s = align_f(trap_target);
      pending_next_s  = 1'b0;
      misalign_next_s = misaligned_f(trap_target);
    end else if (redirect_valid && can_change_s) begin
      fetch_pc_next_s = align_f(redirect_target);
      pending_next_s  = 1'b0;
      misalign_next_s = misaligned_f(redirect_target);
    end else if (redirect_valid) begin
      pending_tgt_next_s = align_f(redirect_target);
      pending_next_s     = 1'b1;
      misalign_next_s    = misaligned_f(redirect_target);
    end else if (pending_r && can_change_s) begin
      fetch_pc_next_s = pending_tgt_r;
      pending_next_s  = 1'b0;
    end else if (hs_s && !stall) begin
      fetch_pc_next_s = fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_next_s = fetch_pc_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid_r <= 1'b0;
      fetch_pc_r    <= RESET_VECTOR;
      pending_r     <= 1'b0;
      pending_tgt_r <= '0;
      misalign_r    <= 1'b0;
      fetch_count_r <= '0;
    end else begin
      fetch_valid_r <= fetch_valid_next_s;
      fetch_pc_r    <= fetch_pc_next_s;
      pending_r     <= pending_next_s;
      pending_tgt_r <= pending_tgt_next_s;
      misalign_r    <= misalign_next_s;
      if (hs_s) begin
        fetch_count_r <= fetch_count_r + CNT_WIDTH'(1);
      end else begin
        fetch_count_r <= fetch_count_r;
      end
    end
  end

  assign fetch_valid      = fetch_valid_r;
  assign fetch_pc         = fetch_pc_r;
  assign redirect_pending = pending_r;
  assign misalign_err     = misalign_r;
  assign fetch_count      = fetch_count_r;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a behavioural model,
// and a narrow instance for PC and counter wrap-around.
module tb_pc_unit;

  localparam int IB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_target = 32'h0;
  logic        fetch_ready = 1'b1;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        redirect_pending;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic        r8 = 1'b1;
  logic        fv8;
  logic [7:0]  pc8;
  logic        rp8;
  logic        me8;
  logic [3:0]  cnt8;

  int n_pass = 0;
  int n_total = 0;

  // behavioural model state
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_mis;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .redirect_pending(redirect_pending),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'h00), .INST_BYTES(4), .CNT_WIDTH(4)) dut8 (
    .clk(clk), .reset(r8), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .trap_valid(1'b0), .trap_target(8'h00), .fetch_ready(1'b1),
    .fetch_valid(fv8), .fetch_pc(pc8), .redirect_pending(rp8),
    .misalign_err(me8), .fetch_count(cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
  endtask

  // One clock of the architectural rules, evaluated on the inputs about to be sampled
  task automatic model_step();
    bit hs;
    bit free;
    hs   = m_run && fetch_ready;
    free = !stall && (!m_run || fetch_ready);
    m_mis = 1'b0;
    if (trap_valid) begin
      m_pc = trap_target - (trap_target % IB);
      m_mis = (trap_target % IB) != 0;
      m_pend = 1'b0;
    end else if (redirect_valid && free) begin
      m_pc = redirect_target - (redirect_target % IB);
      m_mis = (redirect_target % IB) != 0;
      m_pend = 1'b0;
    end else if (redirect_valid) begin
      m_tgt = redirect_target - (redirect_target % IB);
      m_mis = (redirect_target % IB) != 0;
      m_pend = 1'b1;
    end else if (m_pend && free) begin
      m_pc = m_tgt;
      m_pend = 1'b0;
    end else if (hs && !stall) begin
      m_pc = m_pc + IB;
    end
    if (hs) m_cnt = m_cnt + 1;
    m_run = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},   32'(fetch_valid),      32'(m_run));
    chk({tag, ".pc"},      fetch_pc,              m_pc);
    chk({tag, ".pending"}, 32'(redirect_pending), 32'(m_pend));
    chk({tag, ".misalign"},32'(misalign_err),     32'(m_mis));
    chk({tag, ".count"},   fetch_count,           m_cnt);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", fetch_pc, 32'h0);
    chk("rst.count", fetch_count, 32'h0);
    reset = 1'b0;
    chk("rel.valid0", 32'(fetch_valid), 32'h0);

    // sequential fetch from the reset vector
    step("seq0"); chk("seq0.pc", fetch_pc, 32'h0); chk("seq0.cnt", fetch_count, 32'd0);
    step("seq1"); chk("seq1.pc", fetch_pc, 32'h4); chk("seq1.cnt", fetch_count, 32'd1);
    step("seq2"); chk("seq2.pc", fetch_pc, 32'h8); chk("seq2.cnt", fetch_count, 32'd2);

    // deferred redirect under stall
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step("rd100"); chk("rd100.pc", fetch_pc, 32'h100);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    step("stl1"); chk("stl1.pc", fetch_pc, 32'h100); chk("stl1.pend", 32'(redirect_pending), 32'h1);
    step("stl2"); chk("stl2.pc", fetch_pc, 32'h100);
    stall = 1'b0;
    step("unstl"); chk("unstl.pc", fetch_pc, 32'h200); chk("unstl.pend", 32'(redirect_pending), 32'h0);

    // trap beats a same-cycle redirect and clears pending while the request is held
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step("rd40");
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h500;
    step("hold.pend"); chk("hold.pc", fetch_pc, 32'h40);
    trap_valid = 1'b1; trap_target = 32'h80; redirect_valid = 1'b1; redirect_target = 32'h300;
    step("trap"); chk("trap.pc", fetch_pc, 32'h80); chk("trap.pend", 32'(redirect_pending), 32'h0);
    step("trap.hold"); chk("trap.hold.pc", fetch_pc, 32'h80);
    fetch_ready = 1'b1;

    // misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h1003;
    step("mis"); chk("mis.pc", fetch_pc, 32'h1000); chk("mis.flag", 32'(misalign_err), 32'h1);
    step("mis.clr"); chk("mis.clr.flag", 32'(misalign_err), 32'h0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      stall           = ($urandom_range(0, 3) == 0);
      fetch_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 6) == 0);
      trap_valid      = ($urandom_range(0, 19) == 0);
      redirect_target = $urandom;
      trap_target     = $urandom;
      step("rnd");
    end
    stall = 1'b0;

    // async reset with a redirect pending
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h700;
    step("pre.rst"); chk("pre.rst.pend", 32'(redirect_pending), 32'h1);
    #3;
    reset = 1'b1;
    trap_valid = 1'b1; trap_target = 32'h900;
    #1;
    chk("arst.valid", 32'(fetch_valid), 32'h0);
    chk("arst.pc", fetch_pc, 32'h0);
    chk("arst.pend", 32'(redirect_pending), 32'h0);
    chk("arst.mis", 32'(misalign_err), 32'h0);
    chk("arst.cnt", fetch_count, 32'h0);
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    fetch_ready = 1'b1;
    reset = 1'b0;
    model_reset();
    chk("rel2.valid0", 32'(fetch_valid), 32'h0);
    step("rel2.a"); chk("rel2.pc0", fetch_pc, 32'h0);
    step("rel2.b"); chk("rel2.pc4", fetch_pc, 32'h4);

    // narrow instance: PC wraps after 0xFC, 4-bit counter wraps after 16 handshakes
    r8 = 1'b0;
    chk("w8.valid0", 32'(fv8), 32'h0);
    for (int k = 1; k <= 66; k++) begin
      @(posedge clk);
      #1;
      chk("w8.pc", 32'(pc8), 32'((4 * (k - 1)) % 256));
      chk("w8.cnt", 32'(cnt8), 32'((k - 1) % 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
